// File: rtl/urv_dmem_responder_if.sv
// rtl/urv_dmem_responder_if.sv - uRV data-memory bus between core (master) and responder (slave)
interface urv_dmem_responder_if;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_store_i;
    logic        dm_load_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;

    modport master (
        output dm_addr_i,
        output dm_data_s_i,
        output dm_data_select_i,
        output dm_store_i,
        output dm_load_i,
        input  dm_ready_o,
        input  dm_data_l_o,
        input  dm_load_done_o,
        input  dm_store_done_o
    );

    modport slave (
        input  dm_addr_i,
        input  dm_data_s_i,
        input  dm_data_select_i,
        input  dm_store_i,
        input  dm_load_i,
        output dm_ready_o,
        output dm_data_l_o,
        output dm_load_done_o,
        output dm_store_done_o
    );
endinterface

// File: rtl/urv_dmem_responder.sv
// rtl/urv_dmem_responder.sv - data-memory responder with byte lanes, wait states and error flag
module urv_dmem_responder #(
    parameter int g_addr_bits   = 12,
    parameter int g_wait_states = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    urv_dmem_responder_if.slave  dm,
    output logic                 err_o,
    input  logic                 err_clr_i
);
    localparam logic [3:0] WAIT_INIT = 4'(g_wait_states);
    localparam bit         HAS_WAIT  = (g_wait_states != 0);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;

    // Request captured at acceptance; only used when completion is delayed.
    logic [g_addr_bits-1:0]   p_word_q, p_word_d;
    logic [31:0]              p_data_q, p_data_d;
    logic [3:0]               p_sel_q, p_sel_d;
    logic                     p_store_q, p_store_d;
    logic                     p_oor_q, p_oor_d;

    logic [31:0]              data_l_q, data_l_d;
    logic                     load_done_q, load_done_d;
    logic                     store_done_q, store_done_d;
    logic                     err_q, err_d;

    logic [31:0]              mem_q [0:(1 << g_addr_bits) - 1];

    logic                     req;
    logic                     accept;
    logic                     in_oor;
    logic [g_addr_bits-1:0]   in_word;
    logic                     err_event;
    logic                     complete;

    logic [g_addr_bits-1:0]   c_word;
    logic [31:0]              c_data;
    logic [3:0]               c_sel;
    logic                     c_store;
    logic                     c_oor;
    logic                     mem_we;

    // Decode the incoming request: acceptance, word index, range and error events.
    always_comb begin
        req       = dm.dm_load_i | dm.dm_store_i;
        accept    = req && (state_q == S_IDLE);
        in_word   = dm.dm_addr_i[g_addr_bits+1:2];
        in_oor    = (dm.dm_addr_i >> (g_addr_bits + 2)) != 32'd0;
        err_event = accept && (in_oor || (dm.dm_load_i && dm.dm_store_i));
    end

    // FSM next state: zero-wait completes straight from IDLE, otherwise count down in WAIT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_word_d  = p_word_q;
        p_data_d  = p_data_q;
        p_sel_d   = p_sel_q;
        p_store_d = p_store_q;
        p_oor_d   = p_oor_q;
        complete  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!HAS_WAIT) begin
                        complete = 1'b1;
                    end else begin
                        state_d   = S_WAIT;
                        cnt_d     = WAIT_INIT;
                        p_word_d  = in_word;
                        p_data_d  = dm.dm_data_s_i;
                        p_sel_d   = dm.dm_data_select_i;
                        p_store_d = dm.dm_store_i;
                        p_oor_d   = in_oor;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = S_IDLE;
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Completing transaction comes from the live inputs (zero wait) or the captured copy.
    always_comb begin
        c_word  = HAS_WAIT ? p_word_q  : in_word;
        c_data  = HAS_WAIT ? p_data_q  : dm.dm_data_s_i;
        c_sel   = HAS_WAIT ? p_sel_q   : dm.dm_data_select_i;
        c_store = HAS_WAIT ? p_store_q : dm.dm_store_i;
        c_oor   = HAS_WAIT ? p_oor_q   : in_oor;
    end

    // Done strobes, load data and sticky error; an error set beats a same-cycle clear.
    always_comb begin
        load_done_d  = complete && !c_store;
        store_done_d = complete && c_store;
        data_l_d     = data_l_q;
        if (complete && !c_store) begin
            data_l_d = c_oor ? 32'd0 : mem_q[c_word];
        end
        mem_we = complete && c_store && !c_oor && rst_n_i;
        if (err_event) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            p_word_q     <= '0;
            p_data_q     <= 32'd0;
            p_sel_q      <= 4'd0;
            p_store_q    <= 1'b0;
            p_oor_q      <= 1'b0;
            data_l_q     <= 32'd0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            p_word_q     <= p_word_d;
            p_data_q     <= p_data_d;
            p_sel_q      <= p_sel_d;
            p_store_q    <= p_store_d;
            p_oor_q      <= p_oor_d;
            data_l_q     <= data_l_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            err_q        <= err_d;
        end
    end

    // Word array: selected byte lanes are written on the edge that raises the store done.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (c_sel[b]) begin
                    mem_q[c_word][8*b +: 8] <= c_data[8*b +: 8];
                end
            end
        end
    end

    assign dm.dm_ready_o      = (state_q == S_IDLE);
    assign dm.dm_data_l_o     = data_l_q;
    assign dm.dm_load_done_o  = load_done_q;
    assign dm.dm_store_done_o = store_done_q;
    assign err_o              = err_q;
endmodule

// File: tb/tb_urv_dmem_responder.sv
// tb/tb_urv_dmem_responder.sv - scoreboard bench for urv_dmem_responder at zero and three wait states
module tb_urv_dmem_responder;
    typedef struct {
        bit          ld;
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        bit          rst_after;
    } req_t;

    typedef struct {
        int          d;
        bit          st;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n  [2];
    logic [31:0] addr_s [2];
    logic [31:0] data_s [2];
    logic [3:0]  sel_s  [2];
    logic        ld_s   [2];
    logic        st_s   [2];
    logic        clr_s  [2];
    logic        rdy_w  [2];
    logic        ldd_w  [2];
    logic        std_w  [2];
    logic        err_w  [2];
    logic [31:0] dl_w   [2];

    urv_dmem_responder_if bus0 ();
    urv_dmem_responder_if bus1 ();

    assign bus0.dm_addr_i        = addr_s[0];
    assign bus0.dm_data_s_i      = data_s[0];
    assign bus0.dm_data_select_i = sel_s[0];
    assign bus0.dm_load_i        = ld_s[0];
    assign bus0.dm_store_i       = st_s[0];
    assign rdy_w[0]              = bus0.dm_ready_o;
    assign ldd_w[0]              = bus0.dm_load_done_o;
    assign std_w[0]              = bus0.dm_store_done_o;
    assign dl_w[0]               = bus0.dm_data_l_o;

    assign bus1.dm_addr_i        = addr_s[1];
    assign bus1.dm_data_s_i      = data_s[1];
    assign bus1.dm_data_select_i = sel_s[1];
    assign bus1.dm_load_i        = ld_s[1];
    assign bus1.dm_store_i       = st_s[1];
    assign rdy_w[1]              = bus1.dm_ready_o;
    assign ldd_w[1]              = bus1.dm_load_done_o;
    assign std_w[1]              = bus1.dm_store_done_o;
    assign dl_w[1]               = bus1.dm_data_l_o;

    urv_dmem_responder #(.g_addr_bits(12), .g_wait_states(0)) u_dut0 (
        .clk_i     (clk),
        .rst_n_i   (rst_n[0]),
        .dm        (bus0),
        .err_o     (err_w[0]),
        .err_clr_i (clr_s[0])
    );

    urv_dmem_responder #(.g_addr_bits(12), .g_wait_states(3)) u_dut1 (
        .clk_i     (clk),
        .rst_n_i   (rst_n[1]),
        .dm        (bus1),
        .err_o     (err_w[1]),
        .err_clr_i (clr_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          wst [2] = '{0, 3};
    logic [31:0] mdl [2][64];
    int          busy [2];
    bit          err_exp [2];
    bit          err_nxt [2];
    bit          rdy_exp [2];
    logic [31:0] last_ld [2];
    bit          have [2];
    req_t        cur [2];
    int          ptr [2];
    bit          rst_pend [2];
    bit          rst_low [2];
    req_t        plan [$];
    exp_t        sb [$];
    int          cyc;
    int          n_tests;
    int          n_fail;
    bit          running;

    function automatic req_t mk(bit ld, bit st, logic [31:0] a, logic [31:0] dt, logic [3:0] sl, bit ra);
        req_t r;
        r.ld = ld; r.st = st; r.addr = a; r.data = dt; r.sel = sl; r.rst_after = ra;
        return r;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut=%0d cyc=%0d got=%h expected=%h", nm, d, cyc, act, expv);
        end
    endtask

    // One cycle of stimulus for DUT d, updating the reference model on acceptance.
    task automatic step(input int d);
        bit          oor;
        bit          ev;
        logic [31:0] w;
        exp_t        e;
        if (rst_low[d]) begin
            rst_n[d]   = 1'b1;
            rst_low[d] = 1'b0;
        end
        err_exp[d] = err_nxt[d];
        if (rst_pend[d]) begin
            rst_pend[d] = 1'b0;
            rst_low[d]  = 1'b1;
            rst_n[d]    = 1'b0;
            busy[d]     = -1;
            err_exp[d]  = 1'b0;
            err_nxt[d]  = 1'b0;
            last_ld[d]  = 32'd0;
            rdy_exp[d]  = 1'b1;
            ld_s[d]     = 1'b0;
            st_s[d]     = 1'b0;
            clr_s[d]    = 1'b0;
            return;
        end
        rdy_exp[d] = (cyc > busy[d]);
        if (!have[d] && ptr[d] < plan.size() && $urandom_range(0, 2) != 0) begin
            cur[d]  = plan[ptr[d]];
            ptr[d]  = ptr[d] + 1;
            have[d] = 1'b1;
        end
        ld_s[d]   = have[d] && cur[d].ld;
        st_s[d]   = have[d] && cur[d].st;
        addr_s[d] = have[d] ? cur[d].addr : $urandom;
        data_s[d] = have[d] ? cur[d].data : $urandom;
        sel_s[d]  = have[d] ? cur[d].sel  : 4'($urandom);
        clr_s[d]  = ($urandom_range(0, 15) == 0);
        ev = 1'b0;
        if (have[d] && rdy_exp[d]) begin
            oor = (cur[d].addr[31:14] != 18'd0);
            ev  = oor || (cur[d].ld && cur[d].st);
            e.d   = d;
            e.cyc = cyc + wst[d] + 1;
            if (cur[d].rst_after && wst[d] != 0) begin
                rst_pend[d] = 1'b1;
            end else if (cur[d].st) begin
                if (!oor) begin
                    for (int b = 0; b < 4; b++) begin
                        if (cur[d].sel[b]) begin
                            mdl[d][cur[d].addr[7:2]][8*b +: 8] = cur[d].data[8*b +: 8];
                        end
                    end
                end
                e.st = 1'b1; e.data = 32'd0;
                sb.push_back(e);
            end else begin
                w = oor ? 32'd0 : mdl[d][cur[d].addr[7:2]];
                e.st = 1'b0; e.data = w;
                sb.push_back(e);
            end
            busy[d] = cyc + wst[d];
            have[d] = 1'b0;
        end
        err_nxt[d] = ev ? 1'b1 : (clr_s[d] ? 1'b0 : err_exp[d]);
    endtask

    // Monitor: compare handshake, error and done/data against the expected queue.
    always @(negedge clk) begin : mon
        int idx;
        bit el;
        bit es;
        if (running) begin
            for (int d = 0; d < 2; d++) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].d == d) idx = i;
                el = (idx >= 0) && (sb[idx].cyc == cyc) && !sb[idx].st;
                es = (idx >= 0) && (sb[idx].cyc == cyc) && sb[idx].st;
                chk("ready", d, 32'(rdy_w[d]), 32'(rdy_exp[d]));
                chk("err", d, 32'(err_w[d]), 32'(err_exp[d]));
                chk("load_done", d, 32'(ldd_w[d]), 32'(el));
                chk("store_done", d, 32'(std_w[d]), 32'(es));
                if (el) last_ld[d] = sb[idx].data;
                chk("load_data", d, dl_w[d], last_ld[d]);
                if (idx >= 0 && sb[idx].cyc <= cyc) sb.delete(idx);
            end
        end
    end

    initial begin
        bit   busy_any;
        int   r;
        logic [31:0] a;
        n_tests = 0; n_fail = 0; cyc = 0; running = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; addr_s[d] = 32'd0; data_s[d] = 32'd0; sel_s[d] = 4'd0;
            ld_s[d] = 1'b0; st_s[d] = 1'b0; clr_s[d] = 1'b0;
            busy[d] = -1; err_exp[d] = 1'b0; err_nxt[d] = 1'b0; rdy_exp[d] = 1'b1;
            last_ld[d] = 32'd0; have[d] = 1'b0; ptr[d] = 0;
            rst_pend[d] = 1'b0; rst_low[d] = 1'b0;
        end
        for (int i = 0; i < 64; i++) plan.push_back(mk(0, 1, 32'(i * 4), $urandom, 4'hF, 0));
        plan.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0));
        plan.push_back(mk(1, 0, 32'h10, 32'h0, 4'h0, 0));
        plan.push_back(mk(0, 1, 32'h20, 32'h11223344, 4'hF, 0));
        plan.push_back(mk(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0));
        plan.push_back(mk(1, 0, 32'h20, 32'h0, 4'h0, 0));
        plan.push_back(mk(0, 1, 32'h00004000, 32'h12345678, 4'hF, 0));
        plan.push_back(mk(1, 0, 32'h00004000, 32'h0, 4'h0, 0));
        plan.push_back(mk(1, 0, 32'h0, 32'h0, 4'h0, 0));
        plan.push_back(mk(1, 1, 32'h30, 32'h5, 4'hF, 0));
        plan.push_back(mk(1, 0, 32'h30, 32'h0, 4'h0, 0));
        plan.push_back(mk(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0));
        plan.push_back(mk(1, 0, 32'h20, 32'h0, 4'h0, 0));
        plan.push_back(mk(0, 1, 32'h40, 32'h0, 4'hF, 0));
        plan.push_back(mk(0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 1));
        plan.push_back(mk(1, 0, 32'h40, 32'h0, 4'h0, 0));
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            a = {24'd0, 8'($urandom)};
            if (r == 1 || r == 2) begin
                a = $urandom;
                if (a[31:14] == 18'd0) a[14] = 1'b1;
            end
            if (r == 0)      plan.push_back(mk(1, 1, a, $urandom, 4'($urandom), 0));
            else if (r[0])   plan.push_back(mk(1, 0, a, $urandom, 4'($urandom), 0));
            else             plan.push_back(mk(0, 1, a, $urandom, 4'($urandom), 0));
        end

        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        running = 1'b1;
        busy_any = 1'b1;
        while (busy_any && cyc < 20000) begin
            step(0);
            step(1);
            @(posedge clk);
            #1;
            cyc++;
            busy_any = (sb.size() != 0);
            for (int d = 0; d < 2; d++) begin
                if (ptr[d] < plan.size() || have[d] || rst_pend[d] || rst_low[d]) busy_any = 1'b1;
            end
        end
        @(negedge clk);
        running = 1'b0;
        chk("drain_timeout", 0, 32'(busy_any), 32'd0);
        chk("scoreboard_left", 0, 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
